// File: rtl/gif_fetch_pkg.sv
// Shared constants and fetch-FSM encoding for the GIF frame fetcher.
package gif_fetch_pkg;

    localparam int unsigned GIF_ADDR_W   = 26;
    localparam int unsigned GIF_DATA_W   = 128;
    localparam int unsigned PIX_W        = 16;
    localparam int unsigned PIX_PER_WORD = GIF_DATA_W / PIX_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REQ,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/bridge_word_fifo.sv
// Show-ahead word FIFO between the bridge read path and the pixel serialiser.
module bridge_word_fifo
    import gif_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = GIF_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is legal when the same cycle pops.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gif_frame_fetcher.sv
// Fetches one GIF frame over the bridge as 128-bit reads and streams it out
// as RGB565 pixels, lane 0 first.
module gif_frame_fetcher
    import gif_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W      = GIF_ADDR_W,
    parameter int unsigned       DATA_W      = GIF_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       FRAME_BYTES = 153600,
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter int unsigned       TIMEOUT     = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            frame_index,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     bus_address,
    output logic [DATA_W/8-1:0]   bus_byte_enable,
    output logic                  bus_read,
    output logic                  bus_write,
    output logic [DATA_W-1:0]     bus_write_data,
    input  logic                  bus_acknowledge,
    input  logic [DATA_W-1:0]     bus_read_data,
    output logic [PIX_W-1:0]      pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready
);

    localparam int unsigned BYTES_PER_WORD = DATA_W / 8;
    localparam int unsigned NWORDS         = FRAME_BYTES / BYTES_PER_WORD;
    localparam int unsigned WCNT_W         = $clog2(NWORDS + 1);
    localparam int unsigned WAIT_W         = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W          = $clog2(PIX_PER_WORD);

    fetch_state_t                state;
    logic [ADDR_W-1:0]           base;
    logic [WCNT_W-1:0]           word_cnt;
    logic [WAIT_W-1:0]           wait_cnt;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_flush;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [DATA_W-1:0]           fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic [DATA_W-1:0]           ser_word;
    logic [IDX_W-1:0]            ser_idx;
    logic                        ack_hit;
    logic                        timeout_hit;
    logic                        last_pix;

    assign bus_write      = 1'b0;
    assign bus_write_data = '0;

    assign ack_hit     = (state == REQ) && bus_acknowledge;
    assign timeout_hit = (state == REQ) && !bus_acknowledge && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign fifo_push   = ack_hit;
    assign fifo_flush  = timeout_hit;

    // Popping on the acceptance of pixel 7 lets the next word follow without a bubble.
    assign last_pix = pix_valid && pix_ready && (ser_idx == IDX_W'(PIX_PER_WORD - 1));
    assign fifo_pop = !fifo_empty && (!pix_valid || last_pix);
    assign pix_data = ser_word[PIX_W-1:0];

    bridge_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (bus_read_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            base            <= '0;
            word_cnt        <= '0;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            bus_read        <= 1'b0;
            bus_address     <= '0;
            bus_byte_enable <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= BASE_ADDR + ADDR_W'(frame_index) * ADDR_W'(FRAME_BYTES);
                        word_cnt <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (word_cnt == WCNT_W'(NWORDS)) begin
                        state <= DRAIN;
                    end else if (!fifo_full) begin
                        bus_read        <= 1'b1;
                        bus_address     <= base + ADDR_W'(word_cnt) * ADDR_W'(BYTES_PER_WORD);
                        bus_byte_enable <= '1;
                        wait_cnt        <= '0;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (ack_hit) begin
                        bus_read <= 1'b0;
                        word_cnt <= word_cnt + 1'b1;
                        state    <= FILL;
                    end else if (timeout_hit) begin
                        bus_read <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0 && !pix_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Serialiser: shifts the held word down one pixel per accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            ser_word  <= '0;
            ser_idx   <= '0;
        end else if (fifo_flush) begin
            pix_valid <= 1'b0;
            ser_word  <= '0;
            ser_idx   <= '0;
        end else if (fifo_pop) begin
            pix_valid <= 1'b1;
            ser_word  <= fifo_rdata;
            ser_idx   <= '0;
        end else if (pix_valid && pix_ready) begin
            pix_valid <= !last_pix;
            ser_word  <= ser_word >> PIX_W;
            ser_idx   <= ser_idx + 1'b1;
        end
    end

endmodule
